// File: rtl/mips_mdu_pkg.sv
// mips_mdu_pkg: op codes, FSM states and op-class helpers shared by the MDU, the decoder and the stall controller
package mips_mdu_pkg;
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

    function automatic logic is_div(logic [2:0] op);
        return op == MDU_DIV || op == MDU_DIVU;
    endfunction

    function automatic logic is_md(logic [2:0] op);
        return op == MDU_MULT || op == MDU_MULTU || is_div(op);
    endfunction
endpackage

// File: rtl/mips_mdu.sv
// mips_mdu: E-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window
//   clk   in   rising-edge clock
//   reset in   asynchronous active-low reset
//   start in   E-stage MD op valid this cycle
//   op    in   [2:0] operation code (mdu_op_t)
//   a, b  in   [31:0] forwarded rs / rt
//   busy  out  high while a mult/div is in flight
//   hi,lo out  [31:0] HI / LO registers
module mips_mdu
    import mips_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1;

    mdu_state_t    state, state_n;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q, b_q, dvd, dvs, uq, ur;
    logic [2:0]    op_q;
    logic [63:0]   res;
    logic          go, done, wr, sdiv, idle_start;

    assign idle_start = state == IDLE && start;
    assign go         = idle_start && is_md(op);
    assign done       = state == BUSY && cnt == CW'(1);
    // divide by zero completes the busy window but leaves HI/LO untouched
    assign wr         = done && !(is_div(op_q) && b_q == '0);
    assign busy       = state == BUSY;

    // signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    always_comb begin
        sdiv = op_q == MDU_DIV;
        dvd  = sdiv && a_q[31] ? -a_q : a_q;
        dvs  = sdiv && b_q[31] ? -b_q : b_q;
        uq   = dvs == '0 ? '0 : dvd / dvs;
        ur   = dvs == '0 ? '0 : dvd % dvs;
        res  = op_q == MDU_MULT  ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q} :
               op_q == MDU_MULTU ? {32'b0, a_q} * {32'b0, b_q} :
               {sdiv && a_q[31] ? -ur : ur, sdiv && (a_q[31] ^ b_q[31]) ? -uq : uq};
    end

    always_comb state_n = go ? BUSY : done ? IDLE : state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            if (go) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
                cnt  <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else if (busy) begin
                cnt <= cnt - 1'b1;
            end
            if (wr) {hi, lo} <= res;
            if (idle_start && op == MDU_MTHI) hi <= a;
            if (idle_start && op == MDU_MTLO) lo <= a;
        end
    end
endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: directed table-driven check of mips_mdu plus multi-cycle corner sequences
module tb_mips_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy;
    logic [31:0] hi, lo;
    int          n_tests = 0, n_fail = 0;

    mips_mdu dut (.clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                  .busy(busy), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // issue one op, then count negedges with busy high (bounded)
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb, output int cyc);
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
        vecs[4]  = '{3'd3, 32'd5,        32'd0,        32'd1,        32'd3,        10};
        vecs[5]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        vecs[6]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[7]  = '{3'd4, 32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF, 10};
        vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};
        vecs[9]  = '{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'd0,        0};
        vecs[10] = '{3'd6, 32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
        vecs[11] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[12] = '{3'd7, 32'hDEADBEEF, 32'd1,        32'hFFFFFFFE, 32'h00000001, 0};

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        // back-to-back MTHI / MTLO, busy never rises
        @(negedge clk);
        start = 1'b1; op = 3'd5; a = 32'hCAFEF00D;
        @(negedge clk);
        chk("mthi_hi", hi, 32'hCAFEF00D);
        chk("mthi_busy", 32'(busy), 32'd0);
        op = 3'd6; a = 32'h0BADC0DE;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h0BADC0DE);
        chk("mtlo_hi", hi, 32'hCAFEF00D);
        chk("mtlo_busy", 32'(busy), 32'd0);

        // start during busy is ignored
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b1; op = 3'd4;
        @(negedge clk);
        start = 1'b0; op = 3'd6; a = 32'hFFFFFFFF;
        cyc = 2;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("collide_cycles", 32'(cyc), 32'd5);
        chk("collide_hi", hi, 32'd0);
        chk("collide_lo", lo, 32'd12);
        @(negedge clk);
        chk("collide_idle", 32'(busy), 32'd0);

        // async reset in the middle of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_hi", hi, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(3'd6, 32'd5, 32'd0, cyc);
        chk("arst_mtlo_cycles", 32'(cyc), 32'd0);
        repeat (12) @(negedge clk);
        chk("arst_final_lo", lo, 32'd5);
        chk("arst_final_hi", hi, 32'd0);
        chk("arst_final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
